// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for a 4-digit, 7-segment display.
// Drives one digit per ON slot, then blanks all digits for a GAP slot.
// Display content is double-buffered and applied only at the frame boundary.
// The frame boundary is the cycle in which frame_tick is high; the switch takes effect on the edge that ends it.
// Optional feature macro: SEG_SCAN_BLINK_EN (per-digit blink).
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  blink_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        upd_pending,
    output logic        frame_tick
);

    localparam int unsigned TMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam logic [TW-1:0] ON_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } disp_t;
`else
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
    } disp_t;

    // blink_in has no function when blinking is compiled out
    logic unused_blink;
    assign unused_blink = ^blink_in;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic          first_q, first_d;
    disp_t         pend_q, pend_d;
    disp_t         shadow_q, shadow_d;
    logic          upd_q, upd_d;
    logic          tick_q, tick_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
`ifdef SEG_SCAN_BLINK_EN
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bphase_q, bphase_d;
`endif

    // Hex digit to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // True in the last cycle before the scan enters digit 0
    function automatic logic is_wrap(input state_t st, input logic [TW-1:0] t,
                                     input logic [1:0] ix, input logic first);
        logic w;
        if (st == ST_GAP) begin
            w = (t == GAP_LAST) && (first || (ix == 2'd3));
        end else begin
            w = (GAP_CYCLES == 0) && (t == ON_LAST) && (ix == 2'd3);
        end
        return w;
    endfunction

    // Next-state, buffering and registered-output computation
    always_comb begin
        disp_t      in_c;
        logic       boundary_c;
        logic       dark_c;
        logic [3:0] one_hot_c;

        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        idx_d     = idx_q;
        first_d   = first_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        upd_d     = upd_q;
        an_d      = 4'hF;
        seg_d     = SEG_OFF;
        dark_c    = 1'b0;
        one_hot_c = 4'b0001;
`ifdef SEG_SCAN_BLINK_EN
        bcnt_d    = bcnt_q;
        bphase_d  = bphase_q;
        in_c      = '{digits: digits_in, blank: blank_in, blink: blink_in};
`else
        in_c      = '{digits: digits_in, blank: blank_in};
`endif

        boundary_c = is_wrap(state_q, timer_q, idx_q, first_q);

        case (state_q)
            ST_ON: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    if (GAP_CYCLES == 0) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            default: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = ST_ON;
                    idx_d   = first_q ? 2'd0 : (idx_q + 2'd1);
                    first_d = 1'b0;
                end
            end
        endcase

        if (load) begin
            pend_d = in_c;
        end
        if (boundary_c) begin
            shadow_d = load ? in_c : pend_q;
            upd_d    = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
`endif
        end else if (load) begin
            upd_d = 1'b1;
        end

        tick_d = is_wrap(state_d, timer_d, idx_d, first_d);

        if (state_d == ST_ON) begin
            an_d   = ~(one_hot_c << idx_d);
            dark_c = shadow_d.blank[idx_d];
`ifdef SEG_SCAN_BLINK_EN
            dark_c = dark_c || (shadow_d.blink[idx_d] && bphase_d);
`endif
            if (!dark_c) begin
                seg_d = hex_decode(shadow_d.digits[{idx_d, 2'b00} +: 4]);
            end
        end
    end

    // State, buffers and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_GAP;
            timer_q  <= '0;
            idx_q    <= 2'd0;
            first_q  <= 1'b1;
            pend_q   <= '0;
            shadow_q <= '0;
            upd_q    <= 1'b0;
            tick_q   <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= SEG_OFF;
`ifdef SEG_SCAN_BLINK_EN
            bcnt_q   <= '0;
            bphase_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            upd_q    <= upd_d;
            tick_q   <= tick_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
`ifdef SEG_SCAN_BLINK_EN
            bcnt_q   <= bcnt_d;
            bphase_q <= bphase_d;
`endif
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign upd_pending = upd_q;
    assign frame_tick  = tick_q;

endmodule
